paper_cpu_control: RTL

- Fetch/decode/execute sequencer for the 2-bit paper processor.
- Drives the instruction-ROM address and consumes the 2-bit word the ROM returns combinationally in the same cycle.
- Holds PC, instruction register, accumulator and overflow flag; executes INC (00), JNO (01, next word = target), HLT (10).
- Sits directly upstream of the ROM address input and downstream of its data output.

---
 rtl/paper_cpu_control.sv | 121 ++++++++++++
 1 files changed

// File: rtl/paper_cpu_control.sv
// Fetch/decode/execute sequencer for the 2-bit paper processor.
// Ports: clk, rst_n (async low), start; ROM instr_addr/instr_data;
//        acc, ovf, halted, illegal (sticky), retired (wrapping count).
module paper_cpu_control #(
    parameter int         ACC_WIDTH = 2,
    parameter logic [1:0] RESET_PC  = 2'b00,
    parameter int         CNT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [1:0]           instr_data,
    output logic [1:0]           instr_addr,
    output logic [ACC_WIDTH-1:0] acc,
    output logic                 ovf,
    output logic                 halted,
    output logic                 illegal,
    output logic [CNT_WIDTH-1:0] retired
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FETCH   = 3'd1,
        S_EXEC    = 3'd2,
        S_OPERAND = 3'd3,
        S_HALT    = 3'd4
    } state_e;

    state_e               state_q, state_d;
    logic [1:0]           pc_q, pc_d;
    logic [1:0]           ir_q, ir_d;
    logic [ACC_WIDTH-1:0] acc_q, acc_d;
    logic                 ovf_q, ovf_d;
    logic                 ill_q, ill_d;
    logic [CNT_WIDTH-1:0] ret_q, ret_d;

    // One extra bit captures the carry-out of the increment.
    logic [ACC_WIDTH:0]   inc_sum;
    logic [1:0]           pc_inc;
    logic [CNT_WIDTH-1:0] ret_inc;

    assign inc_sum = {1'b0, acc_q} + {{ACC_WIDTH{1'b0}}, 1'b1};
    assign pc_inc  = pc_q + 2'd1;
    assign ret_inc = ret_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        acc_d   = acc_q;
        ovf_d   = ovf_q;
        ill_d   = ill_q;
        ret_d   = ret_q;
        case (state_q)
            S_IDLE: begin
                if (start) state_d = S_FETCH;
            end
            S_FETCH: begin
                ir_d    = instr_data;
                pc_d    = pc_inc;
                state_d = S_EXEC;
            end
            S_EXEC: begin
                case (ir_q)
                    2'b00: begin
                        acc_d   = inc_sum[ACC_WIDTH-1:0];
                        ovf_d   = inc_sum[ACC_WIDTH];
                        ret_d   = ret_inc;
                        state_d = S_FETCH;
                    end
                    2'b01: state_d = S_OPERAND;
                    2'b10: begin
                        ret_d   = ret_inc;
                        state_d = S_HALT;
                    end
                    default: begin
                        // Illegal opcode halts without counting.
                        ill_d   = 1'b1;
                        state_d = S_HALT;
                    end
                endcase
            end
            S_OPERAND: begin
                // The operand word is the jump target; skip it on overflow.
                pc_d    = ovf_q ? pc_inc : instr_data;
                ret_d   = ret_inc;
                state_d = S_FETCH;
            end
            S_HALT: state_d = S_HALT;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            pc_q    <= RESET_PC;
            ir_q    <= 2'b00;
            acc_q   <= '0;
            ovf_q   <= 1'b0;
            ill_q   <= 1'b0;
            ret_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            acc_q   <= acc_d;
            ovf_q   <= ovf_d;
            ill_q   <= ill_d;
            ret_q   <= ret_d;
        end
    end

    assign instr_addr = pc_q;
    assign acc        = acc_q;
    assign ovf        = ovf_q;
    assign halted     = (state_q == S_HALT);
    assign illegal    = ill_q;
    assign retired    = ret_q;

endmodule
